// File: rtl/mc_refresh_sched.sv
// mc_refresh_sched - refresh scheduler for the memory controller.
//
// A prescaler (period rfr_ps_val + 1 cycles) feeds an interval counter. Each
// refresh interval of 2^(ref_int+1) prescaler ticks adds one owed refresh. The
// owed count saturates, and each rfr_ack pays one back. A level request and an
// urgency flag are decoded purely from the owed register.
//
// Optional feature macro: MC_RFR_POSTPONE_EN
//   defined     - owed saturates at MAX_POSTPONE, rfr_urgent at owed >= URGENT_TH
//   not defined - single outstanding request (saturation 1), rfr_urgent tied 0
//
// Ports:
//   clk          controller clock
//   rst_n        synchronous reset, active low
//   cs_need_rfr  per-chip-select "needs refresh" bits; any set enables refresh
//   ref_int      interval select, interval = 2^(ref_int+1) prescaler ticks
//   rfr_ps_val   prescaler terminal count, 0 disables refresh generation
//   rfr_ack      one-cycle pulse, one refresh issued
//   rfr_req      at least one refresh owed
//   rfr_urgent   owed count at or above URGENT_TH
//   rfr_owed     current owed-refresh count
//   rfr_miss     one-cycle pulse, an interval was lost at saturation

module mc_refresh_sched #(
   parameter int unsigned NUM_CS       = 8,
   parameter int unsigned PS_W         = 8,
   parameter int unsigned INT_W        = 8,
   parameter int unsigned MAX_POSTPONE = 8,
   parameter int unsigned URGENT_TH    = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NUM_CS-1:0] cs_need_rfr,
   input  logic [2:0]        ref_int,
   input  logic [PS_W-1:0]   rfr_ps_val,
   input  logic              rfr_ack,
   output logic              rfr_req,
   output logic              rfr_urgent,
   output logic [3:0]        rfr_owed,
   output logic              rfr_miss
);

`ifdef MC_RFR_POSTPONE_EN
   localparam logic [3:0] OwedMax = 4'(MAX_POSTPONE);
`else
   localparam logic [3:0] OwedMax = 4'd1;
`endif

   // Interval counter view at least 8 bits wide; bits above INT_W-1 read as 1.
   localparam int unsigned ExtW = (INT_W > 8) ? INT_W : 8;

   if (MAX_POSTPONE < 1 || MAX_POSTPONE > 15 || URGENT_TH < 1 ||
       URGENT_TH > MAX_POSTPONE) begin : g_bad_cfg
      $error("mc_refresh_sched: invalid MAX_POSTPONE/URGENT_TH");
   end

   logic             rfr_en_q;
   logic [PS_W-1:0]  ps_cnt_q, ps_cnt_d;
   logic [INT_W-1:0] int_cnt_q, int_cnt_d;
   logic [3:0]       owed_q, owed_d;
   logic             miss_q, miss_d;
   logic             ps_tick, int_tick;
   logic [ExtW-1:0]  int_ext;
   logic [7:0]       sel_mask;

   // Tick decode, from registers and static configuration inputs only.
   always_comb begin
      ps_tick = (ps_cnt_q == rfr_ps_val) && (rfr_ps_val != '0);
      int_ext = '1;
      int_ext[INT_W-1:0] = int_cnt_q;
      // Low ref_int+1 bits selected; ref_int = 7 wraps to all ones.
      sel_mask = 8'((9'd2 << ref_int) - 9'd1);
      int_tick = ps_tick && (&(int_ext[7:0] | ~sel_mask));
   end

   // Prescaler and interval counters.
   always_comb begin
      ps_cnt_d = ps_cnt_q + PS_W'(1);
      if (!rfr_en_q || (rfr_ps_val == '0) || ps_tick) begin
         ps_cnt_d = '0;
      end

      int_cnt_d = int_cnt_q;
      if (!rfr_en_q) begin
         int_cnt_d = '0;
      end else if (ps_tick) begin
         int_cnt_d = int_cnt_q + INT_W'(1);
      end
   end

   // Owed-refresh counter, priority top-down.
   always_comb begin
      owed_d = owed_q;
      miss_d = 1'b0;
      if (!rfr_en_q) begin
         owed_d = '0;
      end else if (int_tick && rfr_ack && (owed_q != '0)) begin
         // New interval and a payback cancel out.
         owed_d = owed_q;
      end else if (int_tick && (owed_q == OwedMax)) begin
         miss_d = 1'b1;
      end else if (int_tick) begin
         owed_d = owed_q + 4'd1;
      end else if (rfr_ack && (owed_q != '0)) begin
         owed_d = owed_q - 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rfr_en_q  <= 1'b0;
         ps_cnt_q  <= '0;
         int_cnt_q <= '0;
         owed_q    <= '0;
         miss_q    <= 1'b0;
      end else begin
         rfr_en_q  <= |cs_need_rfr;
         ps_cnt_q  <= ps_cnt_d;
         int_cnt_q <= int_cnt_d;
         owed_q    <= owed_d;
         miss_q    <= miss_d;
      end
   end

   assign rfr_req  = (owed_q != '0);
   assign rfr_owed = owed_q;
   assign rfr_miss = miss_q;

`ifdef MC_RFR_POSTPONE_EN
   assign rfr_urgent = (owed_q >= 4'(URGENT_TH));
`else
   assign rfr_urgent = 1'b0;
`endif

`ifndef SYNTHESIS
   // An ack with nothing owed is a controller protocol error.
   ack_without_owed: assert property (@(posedge clk) disable iff (!rst_n)
      !(rfr_en_q && rfr_ack && (owed_q == '0)));
`endif

endmodule

// File: tb/tb_mc_refresh_sched.sv
// tb_mc_refresh_sched - directed self-checking bench for mc_refresh_sched.
// Inputs change and outputs are sampled on the falling clock edge. cyc counts
// falling edges from the release of reset.

module tb_mc_refresh_sched;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] cs_need_rfr;
   logic [2:0] ref_int;
   logic [7:0] rfr_ps_val;
   logic       rfr_ack;
   logic       rfr_req;
   logic       rfr_urgent;
   logic [3:0] rfr_owed;
   logic       rfr_miss;

   int n_checks = 0;
   int n_fails  = 0;
   int cyc      = 0;
   int waited;
   logic any_req;

`ifdef MC_RFR_POSTPONE_EN
   // Prescaler ticks seen before refresh is paused: 20, so 236 more at period 2.
   localparam int FirstGap = 472;
`else
   // Prescaler ticks seen before refresh is paused: 10, so 246 more at period 2.
   localparam int FirstGap = 492;
`endif

   always #5 clk = ~clk;

   mc_refresh_sched #(
      .NUM_CS      (8),
      .PS_W        (8),
      .INT_W       (8),
      .MAX_POSTPONE(8),
      .URGENT_TH   (6)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cs_need_rfr(cs_need_rfr),
      .ref_int    (ref_int),
      .rfr_ps_val (rfr_ps_val),
      .rfr_ack    (rfr_ack),
      .rfr_req    (rfr_req),
      .rfr_urgent (rfr_urgent),
      .rfr_owed   (rfr_owed),
      .rfr_miss   (rfr_miss)
   );

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic goto(input int c);
      while (cyc < c) step(1);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   initial begin
      rst_n       = 1'b0;
      cs_need_rfr = 8'h00;
      ref_int     = 3'd0;
      rfr_ps_val  = 8'd0;
      rfr_ack     = 1'b0;
      step(3);
      check("rst_req", rfr_req, 0);
      check("rst_urgent", rfr_urgent, 0);
      check("rst_owed", rfr_owed, 0);
      check("rst_miss", rfr_miss, 0);

      // Release reset and enable: ps tick every 4 cycles, interval every 8.
      cyc         = 0;
      rst_n       = 1'b1;
      cs_need_rfr = 8'h01;
      rfr_ps_val  = 8'd3;
      ref_int     = 3'd0;

      goto(8);
      check("first_req_early", rfr_req, 0);
      goto(9);
      check("first_req", rfr_req, 1);
      check("first_owed", rfr_owed, 1);

`ifdef MC_RFR_POSTPONE_EN
      goto(17);
      check("owed_2", rfr_owed, 2);
      goto(41);
      check("owed_5", rfr_owed, 5);
      check("urgent_below_th", rfr_urgent, 0);
      goto(49);
      check("owed_6", rfr_owed, 6);
      check("urgent_at_th", rfr_urgent, 1);
      goto(65);
      check("owed_8", rfr_owed, 8);
      check("no_miss_reaching_max", rfr_miss, 0);
      goto(72);
      check("miss_before_lost", rfr_miss, 0);
      goto(73);
      check("owed_hold_max", rfr_owed, 8);
      check("miss_lost", rfr_miss, 1);
      goto(74);
      check("miss_one_cycle", rfr_miss, 0);
      rfr_ack = 1'b1;               // five acks on edges 75..79
      goto(79);
      rfr_ack = 1'b0;
      check("owed_after_5_acks", rfr_owed, 3);
      goto(80);
      rfr_ack = 1'b1;               // edge 81 carries ack and interval together
      goto(81);
      check("ack_on_tick_owed", rfr_owed, 3);
      check("ack_on_tick_miss", rfr_miss, 0);
      goto(83);
      check("owed_1", rfr_owed, 1);
      check("req_owed_1", rfr_req, 1);
      goto(84);
      rfr_ack = 1'b0;
      check("payback_owed", rfr_owed, 0);
      check("payback_req", rfr_req, 0);
      rfr_ps_val = 8'd0;
`else
      goto(16);
      check("miss_before_lost", rfr_miss, 0);
      goto(17);
      check("miss_lost", rfr_miss, 1);
      check("owed_single", rfr_owed, 1);
      check("urgent_tied", rfr_urgent, 0);
      goto(18);
      check("miss_one_cycle", rfr_miss, 0);
      goto(25);
      check("miss_next_interval", rfr_miss, 1);
      check("owed_still_single", rfr_owed, 1);
      goto(32);
      rfr_ack = 1'b1;               // edge 33 carries ack and interval together
      goto(33);
      rfr_ack = 1'b0;
      check("ack_on_tick_owed", rfr_owed, 1);
      check("ack_on_tick_miss", rfr_miss, 0);
      goto(34);
      rfr_ack = 1'b1;
      goto(35);
      rfr_ack = 1'b0;
      check("payback_owed", rfr_owed, 0);
      check("payback_req", rfr_req, 0);
      goto(41);
      check("req_again", rfr_owed, 1);
      rfr_ack    = 1'b1;
      rfr_ps_val = 8'd0;
      step(1);
      rfr_ack = 1'b0;
      check("ack_with_ps_off", rfr_owed, 0);
`endif

      // Prescaler disabled: nothing may be requested.
      any_req = 1'b0;
      repeat (1000) begin
         step(1);
         if (rfr_req) any_req = 1'b1;
      end
      check("ps_off_no_req", any_req, 0);

      // Period (1 + 1) * 2^8 = 512; int_cnt resumes from its held value.
      rfr_ps_val = 8'd1;
      ref_int    = 3'd7;
      waited     = 0;
      while (!rfr_req && waited < 600) begin
         step(1);
         waited++;
      end
      check("long_first_gap", waited, FirstGap);
      rfr_ack = 1'b1;
      step(1);
      rfr_ack = 1'b0;
      check("long_ack_owed", rfr_owed, 0);
      waited = 1;
      while (!rfr_req && waited < 600) begin
         step(1);
         waited++;
      end
      check("long_period", waited, 512);

      // Dropping the enable clears owed two cycles later.
      cs_need_rfr = 8'h00;
      step(1);
      check("cs_off_lag_owed", rfr_owed, 1);
      step(1);
      check("cs_off_owed", rfr_owed, 0);
      check("cs_off_req", rfr_req, 0);

      // Re-enable with period 4 and check latency, then reset mid-count.
      cs_need_rfr = 8'h80;
      ref_int     = 3'd0;
      step(4);
      check("reen_owed_early", rfr_owed, 0);
      step(1);
      check("reen_owed", rfr_owed, 1);
      step(1);
      rst_n = 1'b0;
      step(1);
      check("midrst_req", rfr_req, 0);
      check("midrst_urgent", rfr_urgent, 0);
      check("midrst_owed", rfr_owed, 0);
      check("midrst_miss", rfr_miss, 0);
      rst_n = 1'b1;
      step(2);
      check("post_rst_owed", rfr_owed, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
